// File: rtl/riscv_core_hazard_scoreboard.sv
// Hazard controller for the RV64IMAC 5-stage pipeline with an M-unit scoreboard.
// Drives operand forwarding, stage stalls and flushes, and exception capture and hold.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rs*_id, i_rs*_ex        source registers in ID and EX
//   i_rd_ex/mem/wb            destination registers in EX, MEM and WB
//   i_regwrite_mem/wb         register-write enables in MEM and WB
//   i_load_ex                 load in EX
//   i_mstart_ex, i_mready     M-op issue request, M unit can accept
//   i_mdone, i_mdone_rd       M-op completion and its destination
//   i_pcsrc_ex                taken branch or jump resolved in EX
//   i_illegal_instr, i_mdivby0, i_mof, i_exc_ack
//                             exception sources, trap acknowledge
//   o_forward[a|b]_ex         00 regfile, 01 WB, 10 MEM, 11 M-unit result
//   o_stall_*, o_flush_*      stage hold and bubble controls
//   o_exception, o_exc_cause  pending exception and its cause
//   o_sb_busy                 any scoreboard bit set
module riscv_core_hazard_scoreboard #(
   parameter int NREGS        = 32,
   parameter int REG_W        = 5,
   parameter int LOAD_BUBBLES = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [REG_W-1:0] i_rs1_id,
   input  logic [REG_W-1:0] i_rs2_id,
   input  logic [REG_W-1:0] i_rs1_ex,
   input  logic [REG_W-1:0] i_rs2_ex,
   input  logic [REG_W-1:0] i_rd_ex,
   input  logic [REG_W-1:0] i_rd_mem,
   input  logic [REG_W-1:0] i_rd_wb,
   input  logic             i_regwrite_mem,
   input  logic             i_regwrite_wb,
   input  logic             i_load_ex,
   input  logic             i_mstart_ex,
   input  logic             i_mready,
   input  logic             i_mdone,
   input  logic [REG_W-1:0] i_mdone_rd,
   input  logic             i_pcsrc_ex,
   input  logic             i_illegal_instr,
   input  logic             i_mdivby0,
   input  logic             i_mof,
   input  logic             i_exc_ack,
   output logic [1:0]       o_forwarda_ex,
   output logic [1:0]       o_forwardb_ex,
   output logic             o_stall_if,
   output logic             o_stall_id,
   output logic             o_stall_ex,
   output logic             o_flush_id,
   output logic             o_flush_ex,
   output logic             o_flush_mem,
   output logic             o_exception,
   output logic [1:0]       o_exc_cause,
   output logic             o_sb_busy
);

   typedef enum logic {
      IDLE,
      PENDING
   } exc_state_e;

   logic [NREGS-1:0] sb_q, sb_d;
   logic [1:0]       cnt_q, cnt_d;
   exc_state_e       state_q, state_d;
   logic [1:0]       cause_q, cause_d;

   logic       ld_hit, lu_stall, raw, waw, pending, issue;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_if, stall_id, stall_ex;
   logic       flush_id, flush_ex, flush_mem;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rd_mem,
      input logic             rw_mem,
      input logic [REG_W-1:0] rd_wb,
      input logic             rw_wb,
      input logic             mdone,
      input logic [REG_W-1:0] mdone_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (rs == '0)                      sel = 2'b00;
      else if (rw_mem && rd_mem == rs)   sel = 2'b10;
      else if (rw_wb && rd_wb == rs)     sel = 2'b01;
      else if (mdone && mdone_rd == rs)  sel = 2'b11;
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(i_rs1_ex, i_rd_mem, i_regwrite_mem,
                      i_rd_wb, i_regwrite_wb, i_mdone, i_mdone_rd);
      fwd_b = fwd_sel(i_rs2_ex, i_rd_mem, i_regwrite_mem,
                      i_rd_wb, i_regwrite_wb, i_mdone, i_mdone_rd);
   end

   always_comb begin
      pending  = (state_q == PENDING);
      ld_hit   = i_load_ex && (i_rd_ex != '0) &&
                 ((i_rs1_id == i_rd_ex) || (i_rs2_id == i_rd_ex));
      // A running bubble count keeps the stall even after the load leaves EX.
      lu_stall = ld_hit || (cnt_q != 2'd0);
      raw      = ((i_rs1_id != '0) && sb_q[i_rs1_id]) ||
                 ((i_rs2_id != '0) && sb_q[i_rs2_id]);
      waw      = i_mstart_ex && (sb_q[i_rd_ex] || !i_mready);
   end

   // Precedence: pending exception, then WAW/structural hold of EX,
   // then branch redirect, then load-use / RAW bubbles.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      flush_mem = 1'b0;
      if (pending) begin
         stall_if  = 1'b1;
         flush_id  = 1'b1;
         flush_ex  = 1'b1;
         flush_mem = 1'b1;
      end else if (waw) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         flush_mem = 1'b1;
      end else if (i_pcsrc_ex) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (lu_stall || raw) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end
   end

   // Bubble counter: a branch that is not held back by EX squashes the load.
   always_comb begin
      cnt_d = cnt_q;
      if (i_pcsrc_ex && !waw)  cnt_d = 2'd0;
      else if (cnt_q != 2'd0)  cnt_d = cnt_q - 2'd1;
      else if (ld_hit)         cnt_d = 2'(LOAD_BUBBLES - 1);
   end

   always_comb begin
      issue = i_mstart_ex && i_mready && (i_rd_ex != '0) && !stall_ex;
      sb_d  = sb_q;
      if (pending && i_exc_ack) begin
         sb_d = '0;
      end else begin
         if (i_mdone) sb_d[i_mdone_rd] = 1'b0;
         // Set after clear so a same-cycle set of the same bit wins.
         if (issue)   sb_d[i_rd_ex]    = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            if (i_illegal_instr || i_mdivby0 || i_mof) begin
               state_d = PENDING;
               if (i_illegal_instr)  cause_d = 2'b01;
               else if (i_mdivby0)   cause_d = 2'b10;
               else                  cause_d = 2'b11;
            end
         end
         PENDING: begin
            if (i_exc_ack) begin
               state_d = IDLE;
               cause_d = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
            cause_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sb_q    <= '0;
         cnt_q   <= 2'd0;
         state_q <= IDLE;
         cause_q <= 2'b00;
      end else begin
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Reset forces every output low, including the combinational ones.
   assign o_forwarda_ex = i_rst_n ? fwd_a : 2'b00;
   assign o_forwardb_ex = i_rst_n ? fwd_b : 2'b00;
   assign o_stall_if    = i_rst_n & stall_if;
   assign o_stall_id    = i_rst_n & stall_id;
   assign o_stall_ex    = i_rst_n & stall_ex;
   assign o_flush_id    = i_rst_n & flush_id;
   assign o_flush_ex    = i_rst_n & flush_ex;
   assign o_flush_mem   = i_rst_n & flush_mem;
   assign o_exception   = i_rst_n & pending;
   assign o_exc_cause   = (i_rst_n && pending) ? cause_q : 2'b00;
   assign o_sb_busy     = i_rst_n & (|sb_q);

endmodule

// File: tb/tb_riscv_core_hazard_scoreboard.sv
// Bench for riscv_core_hazard_scoreboard: LOAD_BUBBLES=1 and =2 instances
// share stimulus and are checked against a rule-level model every cycle.
module tb_riscv_core_hazard_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, mdone_rd;
   logic       rw_mem, rw_wb, load_ex, mstart, mready, mdone, pcsrc;
   logic       ill, dz, mof, ack;

   logic [1:0] fa [2];
   logic [1:0] fb [2];
   logic [1:0] cause_o [2];
   logic       sif [2], sid [2], sex [2];
   logic       fid [2], fex [2], fmem [2];
   logic       exc [2], busy [2];

   int ntot  = 0;
   int nfail = 0;

   // Model state
   bit         sb [32];
   int         cnt [2];
   int         lbv [2] = '{1, 2};
   bit         pend;
   logic [1:0] cause;

   riscv_core_hazard_scoreboard #(.NREGS(32), .REG_W(5), .LOAD_BUBBLES(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
      .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex), .i_rd_ex(rd_ex),
      .i_rd_mem(rd_mem), .i_rd_wb(rd_wb),
      .i_regwrite_mem(rw_mem), .i_regwrite_wb(rw_wb),
      .i_load_ex(load_ex), .i_mstart_ex(mstart), .i_mready(mready),
      .i_mdone(mdone), .i_mdone_rd(mdone_rd), .i_pcsrc_ex(pcsrc),
      .i_illegal_instr(ill), .i_mdivby0(dz), .i_mof(mof), .i_exc_ack(ack),
      .o_forwarda_ex(fa[0]), .o_forwardb_ex(fb[0]),
      .o_stall_if(sif[0]), .o_stall_id(sid[0]), .o_stall_ex(sex[0]),
      .o_flush_id(fid[0]), .o_flush_ex(fex[0]), .o_flush_mem(fmem[0]),
      .o_exception(exc[0]), .o_exc_cause(cause_o[0]), .o_sb_busy(busy[0])
   );

   riscv_core_hazard_scoreboard #(.NREGS(32), .REG_W(5), .LOAD_BUBBLES(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
      .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex), .i_rd_ex(rd_ex),
      .i_rd_mem(rd_mem), .i_rd_wb(rd_wb),
      .i_regwrite_mem(rw_mem), .i_regwrite_wb(rw_wb),
      .i_load_ex(load_ex), .i_mstart_ex(mstart), .i_mready(mready),
      .i_mdone(mdone), .i_mdone_rd(mdone_rd), .i_pcsrc_ex(pcsrc),
      .i_illegal_instr(ill), .i_mdivby0(dz), .i_mof(mof), .i_exc_ack(ack),
      .o_forwarda_ex(fa[1]), .o_forwardb_ex(fb[1]),
      .o_stall_if(sif[1]), .o_stall_id(sid[1]), .o_stall_ex(sex[1]),
      .o_flush_id(fid[1]), .o_flush_ex(fex[1]), .o_flush_mem(fmem[1]),
      .o_exception(exc[1]), .o_exc_cause(cause_o[1]), .o_sb_busy(busy[1])
   );

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 5'd0)                    return 2'b00;
      if (rw_mem && rd_mem == rs)        return 2'b10;
      if (rw_wb && rd_wb == rs)          return 2'b01;
      if (mdone && mdone_rd == rs)       return 2'b11;
      return 2'b00;
   endfunction

   // Packed as {fa, fb, stall_if, stall_id, stall_ex,
   //            flush_id, flush_ex, flush_mem, exception, cause, busy}
   function automatic logic [13:0] exp_out(input int k);
      logic s_if, s_id, s_ex, f_id, f_ex, f_mem, any_sb;
      bit   ld_hit, raw, waw;
      s_if = 0; s_id = 0; s_ex = 0; f_id = 0; f_ex = 0; f_mem = 0;
      any_sb = 0;
      for (int r = 0; r < 32; r++) any_sb |= sb[r];
      ld_hit = load_ex && rd_ex != 0 && (rs1_id == rd_ex || rs2_id == rd_ex);
      raw    = (rs1_id != 0 && sb[rs1_id]) || (rs2_id != 0 && sb[rs2_id]);
      waw    = mstart && (sb[rd_ex] || !mready);
      if (pend) begin
         s_if = 1; f_id = 1; f_ex = 1; f_mem = 1;
      end else if (waw) begin
         s_if = 1; s_id = 1; s_ex = 1; f_mem = 1;
      end else if (pcsrc) begin
         f_id = 1; f_ex = 1;
      end else if (ld_hit || cnt[k] != 0 || raw) begin
         s_if = 1; s_id = 1; f_ex = 1;
      end
      return {m_fwd(rs1_ex), m_fwd(rs2_ex), s_if, s_id, s_ex,
              f_id, f_ex, f_mem, pend, (pend ? cause : 2'b00), any_sb};
   endfunction

   task automatic advance();
      logic [13:0] e;
      bit ld_hit, waw, issue;
      e      = exp_out(0);
      ld_hit = load_ex && rd_ex != 0 && (rs1_id == rd_ex || rs2_id == rd_ex);
      waw    = mstart && (sb[rd_ex] || !mready);
      issue  = mstart && mready && rd_ex != 0 && !e[7];
      for (int k = 0; k < 2; k++) begin
         if (pcsrc && !waw)  cnt[k] = 0;
         else if (cnt[k] > 0) cnt[k] = cnt[k] - 1;
         else if (ld_hit)    cnt[k] = lbv[k] - 1;
      end
      if (pend && ack) begin
         for (int r = 0; r < 32; r++) sb[r] = 0;
      end else begin
         if (mdone) sb[mdone_rd] = 0;
         if (issue) sb[rd_ex] = 1;
      end
      sb[0] = 0;
      if (!pend && (ill || dz || mof)) begin
         pend  = 1;
         cause = ill ? 2'b01 : (dz ? 2'b10 : 2'b11);
      end else if (pend && ack) begin
         pend  = 0;
         cause = 2'b00;
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) sb[r] = 0;
      cnt[0] = 0; cnt[1] = 0;
      pend = 0; cause = 2'b00;
   endtask

   task automatic check(input string tag);
      logic [13:0] e, o;
      for (int k = 0; k < 2; k++) begin
         e = rst_n ? exp_out(k) : 14'h0;
         o = {fa[k], fb[k], sif[k], sid[k], sex[k],
              fid[k], fex[k], fmem[k], exc[k], cause_o[k], busy[k]};
         ntot++;
         assert (o === e) else begin
            nfail++;
            $error("FAIL %s lb=%0d observed=%h expected=%h", tag, lbv[k], o, e);
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step(input string tag);
      #1;
      check(tag);
      advance();
      @(negedge clk);
   endtask

   task automatic idle();
      rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
      rd_mem = 0; rd_wb = 0; mdone_rd = 0;
      rw_mem = 0; rw_wb = 0; load_ex = 0; mstart = 0; mready = 1;
      mdone = 0; pcsrc = 0; ill = 0; dz = 0; mof = 0; ack = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      rs1_ex = 5'd3; rd_mem = 5'd3; rw_mem = 1; load_ex = 1;
      rd_ex = 5'd4; rs1_id = 5'd4; ill = 1;
      #2;
      check("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      step("idle");

      // Load-use: lw x5 in EX, add x6,x5,x7 in ID
      load_ex = 1; rd_ex = 5'd5; rs1_id = 5'd5; rs2_id = 5'd7;
      step("lu_trig");
      load_ex = 0; rd_ex = 0;
      step("lu_b2");
      rs1_id = 0; rs2_id = 0; rs1_ex = 5'd5; rs2_ex = 5'd7;
      rd_wb = 5'd5; rw_wb = 1;
      step("lu_fwd_wb");
      idle();
      step("lu_done");

      // div x10, then consumer in ID until completion
      mstart = 1; rd_ex = 5'd10;
      step("div_issue");
      idle();
      step("div_busy");
      rs1_id = 5'd10;
      step("raw_1");
      step("raw_2");
      mdone = 1; mdone_rd = 5'd10; rs2_ex = 5'd10;
      step("raw_mdone_fwd11");
      idle(); rs1_id = 5'd10;
      step("raw_released");
      idle();

      // WAW on x10
      mstart = 1; rd_ex = 5'd10;
      step("waw_first");
      step("waw_hold");
      pcsrc = 1;
      step("waw_over_branch");
      pcsrc = 0; mdone = 1; mdone_rd = 5'd10;
      step("waw_mdone");
      mdone = 0;
      step("waw_issue");
      mdone = 1; mdone_rd = 5'd10; mstart = 0;
      step("waw_clear");
      mstart = 1; mdone = 1; mdone_rd = 5'd10;
      step("set_clear_same");
      idle(); rs1_id = 5'd10;
      step("set_wins");
      idle(); mready = 0; mstart = 1; rd_ex = 5'd9;
      step("struct_stall");
      idle();

      // Exceptions
      dz = 1; ill = 1;
      step("exc_capture");
      idle();
      for (int i = 0; i < 5; i++) step("exc_hold");
      dz = 1; mof = 1;
      step("exc_ignore_new");
      idle(); ack = 1;
      step("exc_ack");
      idle();
      step("exc_cleared");
      mof = 1; ack = 1;
      step("exc_idle_ack");
      idle();
      step("exc_mof");
      ack = 1;
      step("exc_ack2");
      idle();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rs1_id   = 5'($urandom_range(0, 7));
         rs2_id   = 5'($urandom_range(0, 7));
         rs1_ex   = 5'($urandom_range(0, 7));
         rs2_ex   = 5'($urandom_range(0, 7));
         rd_ex    = 5'($urandom_range(0, 7));
         rd_mem   = 5'($urandom_range(0, 7));
         rd_wb    = 5'($urandom_range(0, 7));
         mdone_rd = 5'($urandom_range(0, 7));
         rw_mem   = ($urandom_range(0, 1) == 0);
         rw_wb    = ($urandom_range(0, 1) == 0);
         load_ex  = ($urandom_range(0, 3) == 0);
         mstart   = ($urandom_range(0, 3) == 0);
         mready   = ($urandom_range(0, 3) != 0);
         mdone    = ($urandom_range(0, 3) == 0);
         pcsrc    = ($urandom_range(0, 7) == 0);
         ill      = ($urandom_range(0, 59) == 0);
         dz       = ($urandom_range(0, 59) == 0);
         mof      = ($urandom_range(0, 59) == 0);
         ack      = ($urandom_range(0, 3) == 0);
         step("rand");
      end

      // Async reset during a load-use bubble with the scoreboard busy
      idle();
      step("pre_rst_idle");
      if (pend) begin
         ack = 1;
         step("pre_rst_ack");
         idle();
      end
      mstart = 1; rd_ex = 5'd3;
      step("pre_rst_div");
      idle(); load_ex = 1; rd_ex = 5'd5; rs1_id = 5'd5;
      step("pre_rst_lu");
      load_ex = 0; rd_ex = 0; rs2_id = 5'd3;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(); rs1_id = 5'd3; rs2_id = 5'd5;
      step("post_rst");
      step("post_rst2");

      $display("%0d/%0d checks passed", ntot - nfail, ntot);
      $finish;
   end

endmodule
